// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 33;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing one asynchronous level into the clk_in domain.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      uart_rxd_in,
    output logic [UART_DATA_BITS-1:0] byte_out,
    output logic                      valid_out,
    output logic                      framing_error_out,
    output logic                      busy_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic                      rxd_s;
    logic [CNT_W-1:0]          clk_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d      (uart_rxd_in),
        .q      (rxd_s)
    );

    assign busy_out = (state != IDLE);

    // Leaving STOP at mid-bit lets a start edge follow the stop bit with no idle gap.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            clk_cnt           <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            byte_out          <= '0;
            valid_out         <= 1'b0;
            framing_error_out <= 1'b0;
        end else begin
            valid_out         <= 1'b0;
            framing_error_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt <= '0;
                        if (rxd_s) begin
                            byte_out  <= shift_reg;
                            valid_out <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            framing_error_out <= 1'b1;
                            state             <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line must reach idle before another start can be seen.
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames with hand-chosen bytes and expected results.
module tb_uart_rx;

    localparam int CPB = 33;

    logic       clk_in;
    logic       rst_in;
    logic       uart_rxd_in;
    logic [7:0] byte_out;
    logic       valid_out;
    logic       framing_error_out;
    logic       busy_out;

    int checkCount;
    int errorCount;
    int ferrCount;
    int overlapCount;
    logic [7:0] rxQ[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .uart_rxd_in       (uart_rxd_in),
        .byte_out          (byte_out),
        .valid_out         (valid_out),
        .framing_error_out (framing_error_out),
        .busy_out          (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Outputs are observed on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (valid_out) rxQ.push_back(byte_out);
        if (framing_error_out) ferrCount++;
        if (valid_out && framing_error_out) overlapCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectByte(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = (rxQ.size() > 0) ? {24'h0, rxQ.pop_front()} : 32'hDEAD;
        checkOutput(tag, got, {24'h0, exp});
    endtask

    // Sends one frame at clks per bit; rstBit >= 0 pulses rst_in mid-way through that frame bit.
    task automatic applyStimulus(input logic [7:0] data, input int clks, input logic stopBit, input int rstBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < clks; c++) begin
                @(posedge clk_in);
                if (c == 0) uart_rxd_in = frame[j];
                rst_in = (j == rstBit && c == clks / 2) ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            uart_rxd_in = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] skewBytes[8];
        int waited;
        checkCount   = 0;
        errorCount   = 0;
        ferrCount    = 0;
        overlapCount = 0;
        rst_in       = 1'b0;
        uart_rxd_in  = 1'b1;

        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_byte", {24'h0, byte_out}, 32'h00);
        checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
        checkOutput("rst_ferr", {31'h0, framing_error_out}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy_out}, 32'h0);
        @(posedge clk_in);
        rst_in = 1'b1;
        idleCycles(5);

        // Loopback-style sweep across the byte range, including 00 and FF.
        for (int i = 0; i < 256; i += 17) begin
            applyStimulus(8'(i), CPB, 1'b1, -1);
            idleCycles(3);
        end
        idleCycles(10);
        for (int i = 0; i < 256; i += 17) expectByte("loopback", 8'(i));
        checkOutput("loopback_ferr", ferrCount, 0);

        // Start-bit glitch shorter than half a bit must be rejected.
        @(posedge clk_in);
        uart_rxd_in = 1'b0;
        repeat (5) @(posedge clk_in);
        uart_rxd_in = 1'b1;
        waited = 0;
        do begin
            @(negedge clk_in);
            waited++;
        end while (busy_out && waited < 20);
        checkOutput("glitch_busy", {31'h0, busy_out}, 32'h0);
        idleCycles(40);
        checkOutput("glitch_valid", rxQ.size(), 0);
        checkOutput("glitch_ferr", ferrCount, 0);

        // Bad stop bit followed by a long low line: one error, byte held.
        applyStimulus(8'hA5, CPB, 1'b0, -1);
        repeat (100) @(posedge clk_in);
        idleCycles(40);
        checkOutput("ferr_count", ferrCount, 1);
        checkOutput("ferr_novalid", rxQ.size(), 0);
        @(negedge clk_in);
        checkOutput("ferr_byte_hold", {24'h0, byte_out}, 32'hFF);
        applyStimulus(8'h3C, CPB, 1'b1, -1);
        idleCycles(10);
        expectByte("after_ferr", 8'h3C);

        // Back-to-back frames with zero idle between stop and start.
        applyStimulus(8'h55, CPB, 1'b1, -1);
        applyStimulus(8'hAA, CPB, 1'b1, -1);
        applyStimulus(8'hFF, CPB, 1'b1, -1);
        applyStimulus(8'h00, CPB, 1'b1, -1);
        idleCycles(10);
        checkOutput("b2b_count", rxQ.size(), 4);
        expectByte("b2b_0", 8'h55);
        expectByte("b2b_1", 8'hAA);
        expectByte("b2b_2", 8'hFF);
        expectByte("b2b_3", 8'h00);

        // Reset during data bit 4 (frame bit index 5) discards the frame.
        applyStimulus(8'hF0, CPB, 1'b1, 5);
        idleCycles(10);
        @(negedge clk_in);
        checkOutput("rstmid_byte", {24'h0, byte_out}, 32'h00);
        checkOutput("rstmid_novalid", rxQ.size(), 0);
        applyStimulus(8'h81, CPB, 1'b1, -1);
        idleCycles(10);
        expectByte("rstmid_next", 8'h81);

        // Baud mismatch on both sides of nominal.
        for (int i = 0; i < 8; i++) begin
            skewBytes[i] = 8'($urandom_range(0, 255));
            applyStimulus(skewBytes[i], (i < 4) ? 32 : 34, 1'b1, -1);
            idleCycles(5);
        end
        idleCycles(10);
        for (int i = 0; i < 8; i++) expectByte("skew", skewBytes[i]);
        checkOutput("skew_ferr", ferrCount, 1);
        checkOutput("pulse_overlap", overlapCount, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Hard stop in case a wait above never completes.
    initial begin
        #5ms;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
